// File: rtl/legv8_alu_pkg.sv
// Shared opcodes, FSM states and flag bundle for the sequential LEGv8 ALU.
// Multiply hardware is present only when LEGV8_ALU_MUL_EN is defined.
package legv8_alu_pkg;

  localparam logic [3:0] OP_AND   = 4'b0000;
  localparam logic [3:0] OP_OR    = 4'b0001;
  localparam logic [3:0] OP_ADD   = 4'b0010;
  localparam logic [3:0] OP_LSL   = 4'b0011;
  localparam logic [3:0] OP_LSR   = 4'b0100;
  localparam logic [3:0] OP_SUB   = 4'b0110;
  localparam logic [3:0] OP_PASSB = 4'b0111;
  localparam logic [3:0] OP_MUL   = 4'b1000;
  localparam logic [3:0] OP_NOR   = 4'b1100;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_MUL_BUSY = 2'd1,
    ST_DONE     = 2'd2
  } state_e;

  typedef struct packed {
    logic z;
    logic n;
    logic c;
    logic v;
  } flags_t;

endpackage

// File: rtl/legv8_mul_iter.sv
// Iterative shift-add multiplier: one multiplier bit per cycle.
// Instantiated by legv8_seq_alu only under LEGV8_ALU_MUL_EN.
module legv8_mul_iter
  import legv8_alu_pkg::*;
#(
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start_i,
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [DATA_W-1:0] product_o
);

  localparam int CNT_W = $clog2(DATA_W);

  logic              busy_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [DATA_W-1:0] mcand_q;
  logic [DATA_W-1:0] mplier_q;
  logic [DATA_W-1:0] acc_q;
  logic [DATA_W-1:0] acc_d;

  assign acc_d = acc_q + (mplier_q[0] ? mcand_q : '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      busy_q   <= 1'b0;
      cnt_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
    end else if (start_i) begin
      busy_q   <= 1'b1;
      cnt_q    <= CNT_W'(DATA_W - 1);
      mcand_q  <= a_i;
      mplier_q <= b_i;
      acc_q    <= '0;
    end else if (busy_q) begin
      acc_q    <= acc_d;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      cnt_q    <= cnt_q - 1'b1;
      if (cnt_q == '0) busy_q <= 1'b0;
    end
  end

  // Final step's sum is exposed directly so the top captures it on done.
  assign busy_o    = busy_q;
  assign done_o    = busy_q & (cnt_q == '0);
  assign product_o = acc_d;

endmodule

// File: rtl/legv8_seq_alu.sv
// Handshaked LEGv8 execute-stage ALU with registered result and NZCV flags.
// Define LEGV8_ALU_MUL_EN to add the iterative multiply (opcode 1000).
module legv8_seq_alu
  import legv8_alu_pkg::*;
#(
  parameter int DATA_W  = 64,
  parameter int SHAMT_W = $clog2(DATA_W)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        ALU_operation,
  input  logic [DATA_W-1:0] A,
  input  logic [DATA_W-1:0] B,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] ALU_result,
  output logic              Zero,
  output logic              Negative,
  output logic              Carry,
  output logic              Overflow
);

  localparam int MSB = DATA_W - 1;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] res_q, res_d;
  flags_t            flg_q, flg_d;

  logic              accept;
  logic              is_mul;
  logic              mul_busy;
  logic              mul_done;
  logic [DATA_W-1:0] mul_prod;

  logic [DATA_W:0]    sum_w;
  logic [DATA_W:0]    dif_w;
  logic [SHAMT_W-1:0] shamt;
  logic [DATA_W-1:0]  alu_res;
  flags_t             alu_flg;

  assign in_ready = (state_q == ST_IDLE) |
                    ((state_q == ST_DONE) & out_ready);
  assign accept   = in_valid & in_ready;

`ifdef LEGV8_ALU_MUL_EN
  logic mul_start;

  assign is_mul    = (ALU_operation == OP_MUL);
  assign mul_start = accept & is_mul;

  legv8_mul_iter #(
    .DATA_W(DATA_W)
  ) u_mul (
    .clk      (clk),
    .reset    (reset),
    .start_i  (mul_start),
    .a_i      (A),
    .b_i      (B),
    .busy_o   (mul_busy),
    .done_o   (mul_done),
    .product_o(mul_prod)
  );
`else
  assign is_mul   = 1'b0;
  assign mul_busy = 1'b0;
  assign mul_done = 1'b0;
  assign mul_prod = '0;
`endif

  // Subtraction as A + ~B + 1 so the carry-out is the no-borrow flag.
  assign sum_w = {1'b0, A} + {1'b0, B};
  assign dif_w = {1'b0, A} + {1'b0, ~B} + (DATA_W+1)'(1);
  assign shamt = B[SHAMT_W-1:0];

  always_comb begin
    alu_res = sum_w[MSB:0];
    alu_flg = '0;
    unique case (1'b1)
      (ALU_operation == OP_AND):   alu_res = A & B;
      (ALU_operation == OP_OR):    alu_res = A | B;
      (ALU_operation == OP_NOR):   alu_res = ~(A | B);
      (ALU_operation == OP_PASSB): alu_res = B;
      (ALU_operation == OP_LSL):   alu_res = A << shamt;
      (ALU_operation == OP_LSR):   alu_res = A >> shamt;
      (ALU_operation == OP_SUB): begin
        alu_res   = dif_w[MSB:0];
        alu_flg.c = dif_w[DATA_W];
        alu_flg.v = (A[MSB] != B[MSB]) & (alu_res[MSB] != A[MSB]);
      end
      default: begin
        alu_res   = sum_w[MSB:0];
        alu_flg.c = sum_w[DATA_W];
        alu_flg.v = (A[MSB] == B[MSB]) & (alu_res[MSB] != A[MSB]);
      end
    endcase
    alu_flg.z = (alu_res == '0);
    alu_flg.n = alu_res[MSB];
  end

  always_comb begin
    state_d = state_q;
    res_d   = res_q;
    flg_d   = flg_q;
    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if ((state_q == ST_DONE) && out_ready) state_d = ST_IDLE;
        if (accept) begin
          if (is_mul) begin
            state_d = ST_MUL_BUSY;
          end else begin
            state_d = ST_DONE;
            res_d   = alu_res;
            flg_d   = alu_flg;
          end
        end
      end
      ST_MUL_BUSY: begin
        if (mul_done) begin
          state_d = ST_DONE;
          res_d   = mul_prod;
          flg_d   = '{z: (mul_prod == '0), n: mul_prod[MSB],
                      c: 1'b0, v: 1'b0};
        end else if (!mul_busy) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      res_q   <= '0;
      flg_q   <= '0;
    end else begin
      state_q <= state_d;
      res_q   <= res_d;
      flg_q   <= flg_d;
    end
  end

  assign out_valid  = (state_q == ST_DONE);
  assign ALU_result = res_q;
  assign Zero       = flg_q.z;
  assign Negative   = flg_q.n;
  assign Carry      = flg_q.c;
  assign Overflow   = flg_q.v;

endmodule

// File: tb/tb_legv8_seq_alu.sv
// Scoreboard bench for legv8_seq_alu; follows LEGV8_ALU_MUL_EN if defined.
// Expected results come from a plain-arithmetic reference model.
module tb_legv8_seq_alu;
  import legv8_alu_pkg::*;

  localparam int W = 64;

`ifdef LEGV8_ALU_MUL_EN
  localparam logic [W-1:0] MUL_EXP = 64'd156;
`else
  localparam logic [W-1:0] MUL_EXP = 64'd25;
`endif

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [3:0]   op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] res;
  logic         z, n, c, v;

  always #5 clk = ~clk;

  legv8_seq_alu #(.DATA_W(W)) dut (
    .clk          (clk),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .ALU_operation(op),
    .A            (a),
    .B            (b),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .ALU_result   (res),
    .Zero         (z),
    .Negative     (n),
    .Carry        (c),
    .Overflow     (v)
  );

  typedef struct packed {
    logic [W-1:0] r;
    logic [3:0]   f;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   last_acc = 0;
  bit   rnd_rdy = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string nm, logic [W-1:0] act, logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic exp_t model(logic [3:0] o, logic [W-1:0] x,
                                 logic [W-1:0] y);
    exp_t              e;
    logic [W:0]        u;
    logic signed [W+1:0] s;
    logic [5:0]        sh;
    logic              fc, fv;
    e  = '0;
    fc = 1'b0;
    fv = 1'b0;
    sh = y[5:0];
`ifdef LEGV8_ALU_MUL_EN
    if (o == OP_MUL) o = 4'hF;
`endif
    case (o)
      OP_AND:   e.r = x & y;
      OP_OR:    e.r = x | y;
      OP_NOR:   e.r = ~(x | y);
      OP_PASSB: e.r = y;
      OP_LSL:   e.r = x << sh;
      OP_LSR:   e.r = x >> sh;
      OP_SUB: begin
        e.r = x - y;
        fc  = (x >= y);
        s   = $signed(x) - $signed(y);
        fv  = (s != $signed(e.r));
      end
      4'hF: begin
`ifdef LEGV8_ALU_MUL_EN
        e.r = x * y;
`else
        u   = x + y;
        e.r = u[W-1:0];
        fc  = u[W];
        s   = $signed(x) + $signed(y);
        fv  = (s != $signed(e.r));
`endif
      end
      default: begin
        u   = x + y;
        e.r = u[W-1:0];
        fc  = u[W];
        s   = $signed(x) + $signed(y);
        fv  = (s != $signed(e.r));
      end
    endcase
    e.f = {(e.r == '0), e.r[W-1], fc, fv};
    return e;
  endfunction

  // Monitor: consume one expectation per output handshake.
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      if (q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_out: got %h want none", res);
      end else begin
        mon_e = q.pop_front();
        chk("result", res, mon_e.r);
        chk("nzcv", {z, n, c, v}, mon_e.f);
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rnd_rdy) out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  task automatic issue(logic [3:0] o, logic [W-1:0] x, logic [W-1:0] y,
                       bit latchk);
    int cnt;
    bit acc;
    bit ok;
    op = o;
    a = x;
    b = y;
    in_valid = 1'b1;
    cnt = 0;
    do begin
      acc = in_ready;
      @(posedge clk);
      #2;
      cnt++;
    end while (!acc && cnt < 300);
    in_valid = 1'b0;
    a = ~x;
    b = ~y;
    if (!acc) begin
      total++;
      bad++;
      $display("FAIL accept_timeout: got no accept want accept");
      return;
    end
    last_acc = cyc;
    q.push_back(model(o, x, y));
    if (latchk) begin
`ifdef LEGV8_ALU_MUL_EN
      if (o == OP_MUL) begin
        ok = 1'b1;
        for (int i = 0; i < W; i++) begin
          if (i > 0) begin
            @(posedge clk);
            #2;
          end
          if (in_ready || out_valid) ok = 1'b0;
        end
        chk("mul_busy", ok, 1);
        @(posedge clk);
        #2;
      end
`endif
      chk("latency_valid", out_valid, 1);
    end
  endtask

  function automatic logic [W-1:0] rnd_val();
    case ($urandom_range(0, 4))
      0: return W'($urandom_range(0, 20));
      1: return '1;
      2: return {1'b1, {(W-1){1'b0}}};
      3: return {1'b0, {(W-1){1'b1}}};
      default: return {$urandom, $urandom};
    endcase
  endfunction

  initial begin
    logic [W-1:0] r0;
    int           c1;
    bit           ok;
    int           guard;

    reset     = 1'b1;
    in_valid  = 1'b0;
    op        = '0;
    a         = '0;
    b         = '0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    reset = 1'b0;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_result", res, 0);
    chk("rst_nzcv", {z, n, c, v}, 0);
    chk("rst_in_ready", in_ready, 1);

    issue(OP_ADD, '1, 64'd1, 1);
    chk("add_wrap_res", res, 0);
    chk("add_wrap_nzcv", {z, n, c, v}, 4'b1010);
    issue(OP_SUB, 64'd5, 64'd7, 1);
    chk("sub_res", res, 64'hFFFF_FFFF_FFFF_FFFE);
    chk("sub_nzcv", {z, n, c, v}, 4'b0100);
    issue(OP_ADD, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1);
    chk("add_ovf_res", res, 64'h8000_0000_0000_0000);
    chk("add_ovf_nzcv", {z, n, c, v}, 4'b0101);
    issue(OP_LSL, 64'd1, 64'h43, 1);
    chk("lsl_res", res, 64'd8);
    issue(OP_LSR, 64'h80, 64'hFFC0, 1);
    chk("lsr_zero_shamt", res, 64'h80);

    issue(OP_MUL, 64'd12, 64'd13, 1);
    chk("mul_res", res, MUL_EXP);

    issue(OP_AND, 64'hF0F0, 64'hFF00, 1);
    c1 = last_acc;
    issue(OP_OR, 64'hF0F0, 64'h0F0F, 1);
    issue(OP_NOR, 64'h0, 64'h1, 1);
    chk("b2b_cycles", W'(last_acc - c1), 2);

    issue(OP_PASSB, 64'h1234, 64'hDEAD_BEEF, 1);
    out_ready = 1'b0;
    r0 = res;
    ok = 1'b1;
    repeat (3) begin
      @(posedge clk);
      #2;
      if (res !== r0 || in_ready || !out_valid) ok = 1'b0;
    end
    chk("stall_hold", ok, 1);
    out_ready = 1'b1;
    @(posedge clk);
    #2;

    rnd_rdy = 1'b1;
    repeat (40) issue(4'($urandom_range(0, 15)), rnd_val(), rnd_val(), 1);
    rnd_rdy = 1'b0;
    @(posedge clk);
    #2;
    out_ready = 1'b1;
    guard = 0;
    while (q.size() != 0 && guard < 200) begin
      @(posedge clk);
      #2;
      guard++;
    end
    chk("drain_empty", W'(q.size()), 0);

    out_ready = 1'b0;
    issue(OP_MUL, 64'd3, 64'd4, 0);
    repeat (9) begin
      @(posedge clk);
      #2;
    end
    reset = 1'b1;
    @(posedge clk);
    #2;
    reset = 1'b0;
    q.delete();
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_ready", in_ready, 1);
    chk("mid_rst_result", res, 0);
    out_ready = 1'b1;
    ok = 1'b1;
    repeat (70) begin
      @(posedge clk);
      #2;
      if (out_valid) ok = 1'b0;
    end
    chk("no_late_result", ok, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #900_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

endmodule
